// File: rtl/soc_system_result_pkg.sv
// soc_system_result_pkg: shared bit indices and holding-register state type for the result sequencer
package soc_system_result_pkg;
  localparam int STAT_VALID = 0;
  localparam int STAT_LAST = 1;
  localparam int STAT_ACK = 2;
  localparam int STAT_UNDERRUN = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int CTRL_REQ = 0;
  localparam int CTRL_FLUSH = 1;
  typedef enum logic {EMPTY, LOADED} hold_state_e;
endpackage

// File: rtl/soc_system_result_fifo.sv
// soc_system_result_fifo: show-ahead synchronous FIFO of result words plus their last flag
module soc_system_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W:0]   wdata,
  output logic [DATA_W:0]   rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  assign rdata = mem[rptr];
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  // pointers wrap naturally; occupancy alone decides full/empty
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  always_ff @(posedge clk)
    if (push && !clear) mem[wptr] <= wdata;
endmodule

// File: rtl/soc_system_result_sequencer.sv
// soc_system_result_sequencer: buffers coprocessor results and hands them to the HPS one word per req/ack toggle
module soc_system_result_sequencer
  import soc_system_result_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_last,
  input  logic [1:0]        ctrl_in,
  output logic [DATA_W-1:0] pio_data,
  output logic [7:0]        pio_status
);
  logic push, pop, full, empty, flush, toggle, req_q, rd_ack, underrun, hold_last;
  logic [DATA_W:0] rdata;
  logic [CNT_W-1:0] count;
  hold_state_e state, state_nx;
  assign flush = ctrl_in[CTRL_FLUSH];
  assign toggle = ctrl_in[CTRL_REQ] != req_q;
  assign res_ready = reset_n && !full && !flush;
  assign push = res_valid && res_ready;
  // an empty holding register refills on its own; a loaded one only on consume
  assign pop = !flush && !empty && (state == EMPTY || toggle);
  soc_system_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .clear(flush),
    .wdata({res_last, res_data}), .rdata(rdata), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= EMPTY;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (flush) state_nx = EMPTY;
    else if (state == EMPTY) state_nx = empty ? EMPTY : LOADED;
    else if (toggle && empty) state_nx = EMPTY;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      req_q <= 1'b0;
      rd_ack <= 1'b0;
      underrun <= 1'b0;
      hold_last <= 1'b0;
      pio_data <= '0;
    end else begin
      req_q <= ctrl_in[CTRL_REQ];
      if (flush || toggle) rd_ack <= ctrl_in[CTRL_REQ];
      if (flush) begin
        underrun <= 1'b0;
        hold_last <= 1'b0;
        pio_data <= '0;
      end else begin
        if (toggle && state == EMPTY) underrun <= 1'b1;
        if (pop) begin
          pio_data <= rdata[DATA_W-1:0];
          hold_last <= rdata[DATA_W];
        end else if (toggle) hold_last <= 1'b0;
      end
    end
  always_comb begin
    pio_status = '0;
    pio_status[STAT_VALID] = state == LOADED;
    pio_status[STAT_LAST] = hold_last;
    pio_status[STAT_ACK] = rd_ack;
    pio_status[STAT_UNDERRUN] = underrun;
    pio_status[STAT_CNT_LSB +: 4] = 4'(count);
  end
endmodule

// File: tb/tb_soc_system_result_sequencer.sv
// tb_soc_system_result_sequencer: directed and randomized checks against a queue-based model
module tb_soc_system_result_sequencer;
  localparam int DEPTH = 8;
  logic clk = 0, reset_n = 0, res_valid = 0, res_ready, res_last = 0;
  logic [31:0] res_data = '0, pio_data;
  logic [1:0] ctrl_in = '0;
  logic [7:0] pio_status;
  int n_checks = 0, n_err = 0;
  bit [32:0] q[$];
  bit hv, hl, ack, und, mreq, exp_ready, acc;
  bit [31:0] hd;
  soc_system_result_sequencer #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last), .ctrl_in(ctrl_in),
    .pio_data(pio_data), .pio_status(pio_status)
  );
  always #5 clk = ~clk;
  function automatic bit [7:0] exp_status();
    return {4'(q.size()), und, ack, hl, hv};
  endfunction
  task automatic model_reset();
    q.delete();
    {hv, hl, ack, und, mreq} = '0;
    hd = '0;
  endtask
  task automatic load_or_drain();
    bit [32:0] w;
    if (q.size() > 0) begin
      w = q.pop_front();
      hv = 1; hd = w[31:0]; hl = w[32];
    end else begin
      hv = 0; hl = 0;
    end
  endtask
  // one clock edge: the model sees the same inputs the DUT samples
  task automatic cyc();
    bit tog;
    exp_ready = (q.size() < DEPTH) && !ctrl_in[1];
    acc = res_valid && exp_ready;
    @(posedge clk);
    tog = ctrl_in[0] != mreq;
    if (ctrl_in[1]) begin
      q.delete();
      hv = 0; hl = 0; hd = '0; und = 0; ack = ctrl_in[0];
    end else begin
      if (tog) ack = ctrl_in[0];
      if (!hv) begin
        if (tog) und = 1;
        if (q.size() > 0) load_or_drain();
      end else if (tog) load_or_drain();
      if (acc) q.push_back({res_last, res_data});
    end
    mreq = ctrl_in[0];
    #1;
  endtask
  task automatic test_reset();
    reset_n = 0; ctrl_in = '0; res_valid = 0;
    #7;
    n_checks += 3;
    if (pio_status !== 8'h00) begin n_err++; $display("FAIL reset_status got=%h exp=00", pio_status); end
    if (pio_data !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", pio_data); end
    if (res_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", res_ready); end
    @(posedge clk); #1 reset_n = 1;
    model_reset();
    #1 n_checks++;
    if (res_ready !== 1'b1) begin n_err++; $display("FAIL release_ready got=%b exp=1", res_ready); end
  endtask
  task automatic test_single();
    res_valid = 1; res_data = 32'hDEADBEEF; res_last = 1;
    cyc();
    res_valid = 0; res_last = 0;
    cyc();
    n_checks += 3;
    if (pio_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data got=%h exp=deadbeef", pio_data); end
    if (pio_status !== 8'h03) begin n_err++; $display("FAIL single_status got=%h exp=03", pio_status); end
    ctrl_in[0] = 1;
    cyc();
    if (pio_status !== 8'h04) begin n_err++; $display("FAIL single_ack got=%h exp=04", pio_status); end
  endtask
  task automatic test_fill();
    int n = 0;
    for (int i = 0; i < 12; i++) begin
      res_valid = 1; res_data = n; cyc();
      if (acc) n++;
    end
    n_checks += 3;
    if (res_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got=%b exp=0", res_ready); end
    if (pio_status[7:4] !== 4'd8) begin n_err++; $display("FAIL fill_count got=%0d exp=8", pio_status[7:4]); end
    if (pio_data !== 32'd0) begin n_err++; $display("FAIL fill_hold got=%h exp=0", pio_data); end
    for (int i = 1; i <= 9; i++) begin
      ctrl_in[0] = ~ctrl_in[0];
      res_valid = n < 10; res_data = n;
      cyc();
      if (acc) n++;
      n_checks += 2;
      if (pio_data !== 32'(i)) begin n_err++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, pio_data, i); end
      if (pio_status[2] !== ctrl_in[0]) begin n_err++; $display("FAIL drain_ack[%0d] got=%b exp=%b", i, pio_status[2], ctrl_in[0]); end
    end
    res_valid = 0;
    ctrl_in[0] = ~ctrl_in[0];
    cyc();
    n_checks++;
    if (pio_status !== {5'b0, ctrl_in[0], 2'b00}) begin n_err++; $display("FAIL drain_empty got=%h", pio_status); end
  endtask
  task automatic test_underrun();
    ctrl_in[0] = ~ctrl_in[0];
    cyc();
    n_checks += 3;
    if (pio_status !== {4'h0, 1'b1, ctrl_in[0], 2'b00}) begin n_err++; $display("FAIL underrun_set got=%h", pio_status); end
    res_valid = 1; res_data = 32'hA5A50001;
    cyc();
    res_valid = 0;
    cyc();
    if (pio_data !== 32'hA5A50001) begin n_err++; $display("FAIL underrun_load got=%h exp=a5a50001", pio_data); end
    if (pio_status !== {4'h0, 1'b1, ctrl_in[0], 2'b01}) begin n_err++; $display("FAIL underrun_sticky got=%h", pio_status); end
  endtask
  task automatic test_push_pop();
    for (int i = 0; i < 3; i++) begin
      res_valid = 1; res_data = 32'hB0 + i; cyc();
    end
    n_checks += 2;
    if (pio_status[7:4] !== 4'd3) begin n_err++; $display("FAIL pp_count_pre got=%0d exp=3", pio_status[7:4]); end
    res_data = 32'hB3; ctrl_in[0] = ~ctrl_in[0];
    cyc();
    res_valid = 0;
    if (pio_status[7:4] !== 4'd3 || pio_data !== 32'hB0) begin
      n_err++; $display("FAIL pp_same_cycle got=%0d/%h exp=3/b0", pio_status[7:4], pio_data);
    end
    for (int i = 1; i <= 3; i++) begin
      ctrl_in[0] = ~ctrl_in[0];
      cyc();
      n_checks++;
      if (pio_data !== 32'hB0 + i) begin n_err++; $display("FAIL pp_drain[%0d] got=%h exp=%h", i, pio_data, 32'hB0 + i); end
    end
  endtask
  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      res_valid = 1; res_data = 32'hC0 + i; cyc();
    end
    n_checks += 6;
    if (pio_status[7:4] !== 4'd5) begin n_err++; $display("FAIL flush_pre got=%0d exp=5", pio_status[7:4]); end
    ctrl_in = {1'b1, ~ctrl_in[0]};
    cyc();
    if (res_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%b exp=0", res_ready); end
    if (pio_status !== {5'b0, ctrl_in[0], 2'b00} || pio_data !== 32'h0) begin
      n_err++; $display("FAIL flush_active got=%h/%h", pio_status, pio_data);
    end
    cyc();
    ctrl_in[1] = 0; res_valid = 0;
    cyc();
    if (pio_status !== {5'b0, ctrl_in[0], 2'b00} || pio_data !== 32'h0) begin
      n_err++; $display("FAIL flush_release got=%h/%h", pio_status, pio_data);
    end
    if (res_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_after got=%b exp=1", res_ready); end
    cyc();
    if (pio_status !== {5'b0, ctrl_in[0], 2'b00}) begin n_err++; $display("FAIL flush_no_spurious got=%h", pio_status); end
  endtask
  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      res_valid = $urandom_range(2) != 0;
      res_data = $urandom;
      res_last = $urandom_range(1);
      if ($urandom_range(3) == 0) ctrl_in[0] = ~ctrl_in[0];
      ctrl_in[1] = $urandom_range(19) == 0;
      #1 n_checks += 3;
      if (res_ready !== ((q.size() < DEPTH) && !ctrl_in[1])) begin
        n_err++; $display("FAIL rand_ready[%0d] got=%b", i, res_ready);
      end
      cyc();
      if (pio_data !== hd) begin n_err++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, pio_data, hd); end
      if (pio_status !== exp_status()) begin
        n_err++; $display("FAIL rand_status[%0d] got=%h exp=%h", i, pio_status, exp_status());
      end
    end
  endtask
  task automatic test_reset_mid();
    res_valid = 1; res_data = 32'h1234; ctrl_in = '0;
    #2 reset_n = 0;
    #1 n_checks += 4;
    if (pio_status !== 8'h00 || pio_data !== 32'h0) begin
      n_err++; $display("FAIL mid_reset got=%h/%h exp=00/0", pio_status, pio_data);
    end
    if (res_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_ready got=%b exp=0", res_ready); end
    res_valid = 0;
    @(posedge clk); #1 reset_n = 1;
    model_reset();
    #1;
    if (res_ready !== 1'b1) begin n_err++; $display("FAIL mid_release_ready got=%b exp=1", res_ready); end
    if (pio_status !== 8'h00) begin n_err++; $display("FAIL mid_release_status got=%h exp=00", pio_status); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_underrun();
    test_push_pop();
    test_flush();
    test_random(600);
    test_reset_mid();
    test_random(300);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/soc_system_result_sequencer.md
Name: soc_system_result_sequencer

Overview:
Drains result words from the matrix coprocessor and presents them one at a time to the HPS through the 32-bit data_out PIO input port.
- Buffers coprocessor results in a small synchronous FIFO.
- Paces delivery with a toggle req/ack handshake carried on a control output PIO and a status input PIO.
- Sits between the coprocessor result interface and the soc_system PIO slaves in the FPGA fabric.

Parameters:
- DATA_W, 32, result word width; must equal the data_out PIO width.
- DEPTH, 8, FIFO depth in words; power of two, minimum 2.
- CNT_W, 4, occupancy counter width; equals log2(DEPTH)+1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- res_valid  in  1  coprocessor result word valid.
- res_ready  out  1  block can accept a result word.
- res_data  in  DATA_W  coprocessor result word.
- res_last  in  1  marks the final word of a result matrix.
- ctrl_in  in  2  from the control PIO; bit0 rd_req (toggle), bit1 flush (level).
- pio_data  out  DATA_W  drives the data_out PIO in_port; current holding word.
- pio_status  out  8  drives the status PIO. Bit map: [0] hold_valid, [1] hold_last, [2] rd_ack, [3] underrun (sticky), [7:4] fifo_count.

Behaviour:
- Reset (asynchronous, reset_n=0): all registers clear.
  - pio_data=0; pio_status=0; FIFO empty; req_q=0.
  - res_ready=0 while in reset.
- Out of reset: res_ready = !fifo_full && !flush (combinational).
- Coprocessor push: a word is written when res_valid && res_ready at a rising edge. res_last is stored with the word (DATA_W+1 bits).
- Holding register FSM:
  - States: EMPTY (hold_valid=0) and LOADED (hold_valid=1).
  - EMPTY -> LOADED: FIFO non-empty. Pop the head into pio_data/hold_last; visible one cycle after the word lands in the FIFO. Minimum latency from push to hold_valid=1 is 2 cycles.
  - LOADED -> LOADED: consume toggle and FIFO non-empty. Pop the next word in the same cycle.
  - LOADED -> EMPTY: consume toggle and FIFO empty. pio_data holds its last value; hold_valid=0, hold_last=0.
- Consume detection: toggle = ctrl_in[0] != req_q. req_q registers ctrl_in[0] every cycle.
- On toggle: rd_ack <= ctrl_in[0] on the same edge. Software sees ack==req one cycle after its write.
- Toggle while EMPTY: no pop; rd_ack still follows req; underrun <= 1.
- Underrun is sticky. It clears only on flush or reset.
- Simultaneous push and pop: count is unchanged; both take effect.
- Push into a full FIFO cannot occur because res_ready=0 then.
- Pop from an empty FIFO never occurs.
- fifo_count reports FIFO occupancy only and excludes the holding word. Range 0..DEPTH.
- Flush, checked every cycle while ctrl_in[1]=1, overrides push, pop and toggle:
  - FIFO emptied; hold_valid=0, hold_last=0, underrun=0.
  - rd_ack <= ctrl_in[0] and req_q tracks, so no spurious toggle is seen when flush is released.
  - pio_data=0.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; full/empty derive from the count.
- Reset mid-transfer: all state is lost immediately. The coprocessor must re-send; no partial handshake survives.

Decomposition:
- Package soc_system_result_pkg:
  - status bit index constants STAT_VALID=0, STAT_LAST=1, STAT_ACK=2, STAT_UNDERRUN=3, STAT_CNT_LSB=4.
  - control bit indices CTRL_REQ=0, CTRL_FLUSH=1.
- One sub-module, soc_system_result_fifo:
  - synchronous FIFO, width DATA_W+1, depth DEPTH.
  - ports clk, reset_n, push, pop, wdata, rdata (show-ahead), count, full, empty, clear.
- The top level holds the handshake logic, holding register and status packing.

Test Plan:
- Reset then idle: pio_status=0x00, pio_data=0. After reset release, res_ready=1 with ctrl_in=0.
- Push 0xDEADBEEF (last=1) -> 2 cycles later pio_data=0xDEADBEEF, status=0x03. Toggle req 0->1 -> next cycle status=0x04 (ack=1, empty).
- Push 10 words 0x0..0x9 with no consumes: res_ready drops after 9 accepted (1 held + 8 buffered); status[7:4]=8. Nine toggles then deliver 0x1..0x9 in order, with each ack matching req one cycle after its toggle.
- Toggle while EMPTY -> underrun=1 (status=0x0C after a 0->1 toggle). Subsequent push loads normally and underrun stays 1.
- Push and toggle in the same cycle with fifo_count=3: count stays 3, next word presented, no data loss.
- Flush asserted with 5 words queued and req toggled during flush: after release, status=0x00 | (req<<2), pio_data=0, res_ready=1, and no spurious pop.
